// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Purpose  : Shared entry type and helpers for the forwarding/hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    // The rd field is sized for the widest supported register address, so REG_AW must be <= FWD_RD_W.
    localparam int FWD_RD_W = 8;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                regwrite;
        logic                memread;
        logic                setflags;
    } fwd_entry_t;

    localparam int FWD_ENTRY_W = $bits(fwd_entry_t);
    localparam int FWD_SEL_RF  = 0;

    function automatic logic entry_writes(input fwd_entry_t e, input logic [FWD_RD_W-1:0] zero_reg);
        return e.valid & e.regwrite & (e.rd != zero_reg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fwd_stage_pipe
// Purpose  : Shift register of in-flight destination entries (EX .. EX+DEPTH).
// Revision : 1.0 - initial release
// ============================================================================
module fwd_stage_pipe
    import fwd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                               clk,
    input  wire logic                               rst,
    input  wire logic                               i_hold,
    input  wire logic                               i_bubble,
    input  wire logic [FWD_ENTRY_W-1:0]             i_entry,
    output logic      [(DEPTH+1)*FWD_ENTRY_W-1:0]   o_entries
);

    fwd_entry_t r_s [DEPTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DEPTH; k++) begin
                r_s[k] <= '0;
            end
        end else if (!i_hold) begin
            r_s[0] <= i_bubble ? '0 : fwd_entry_t'(i_entry);
            for (int k = 1; k <= DEPTH; k++) begin
                r_s[k] <= r_s[k-1];
            end
        end
    end

    generate
        for (genvar k = 0; k <= DEPTH; k++) begin : g_pack
            assign o_entries[k*FWD_ENTRY_W +: FWD_ENTRY_W] = r_s[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Purpose  : EX forward selects, load-use stall and flag forwarding from
//            internally tracked in-flight destination registers.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ZERO_REG  = 31,
    parameter int NUM_SRC   = 3,
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = $clog2(FWD_DEPTH+1)
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      id_valid,
    input  wire logic [REG_AW-1:0]         id_rd,
    input  wire logic                      id_regwrite,
    input  wire logic                      id_memread,
    input  wire logic                      id_setflags,
    input  wire logic                      id_branch,
    input  wire logic [NUM_SRC*REG_AW-1:0] id_src,
    input  wire logic [NUM_SRC-1:0]        id_src_use,
    input  wire logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  wire logic [NUM_SRC-1:0]        ex_src_use,
    input  wire logic                      pipe_hold,
    input  wire logic                      flush,
    output logic      [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                           load_use_stall,
    output logic                           flag_fwd,
    output logic                           flag_busy
);

    localparam logic [FWD_RD_W-1:0] c_ZERO_RD = FWD_RD_W'(ZERO_REG);

    fwd_entry_t                              w_in_entry;
    logic [(FWD_DEPTH+1)*FWD_ENTRY_W-1:0]    w_entries;
    fwd_entry_t                              w_s [FWD_DEPTH+1];
    logic [NUM_SRC*SEL_W-1:0]                w_fwd_sel;
    logic                                    w_src_hit;
    logic                                    w_stall;
    logic                                    w_flag_busy;

    assign w_in_entry = '{valid:    id_valid,
                          rd:       FWD_RD_W'(id_rd),
                          regwrite: id_regwrite,
                          memread:  id_memread,
                          setflags: id_setflags};

    fwd_stage_pipe #(
        .DEPTH (FWD_DEPTH)
    ) u_pipe (
        .clk       (clk),
        .rst       (reset),
        .i_hold    (pipe_hold),
        .i_bubble  (w_stall | flush),
        .i_entry   (w_in_entry),
        .o_entries (w_entries)
    );

    generate
        for (genvar k = 0; k <= FWD_DEPTH; k++) begin : g_unpack
            assign w_s[k] = fwd_entry_t'(w_entries[k*FWD_ENTRY_W +: FWD_ENTRY_W]);
        end
    endgenerate

    // Scan farthest to nearest so the youngest matching producer overrides.
    always_comb begin
        w_fwd_sel = {NUM_SRC{SEL_W'(FWD_SEL_RF)}};
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (ex_src_use[i] && entry_writes(w_s[k], c_ZERO_RD) &&
                    (w_s[k].rd == FWD_RD_W'(ex_src[i*REG_AW +: REG_AW]))) begin
                    w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        w_src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_use[i] && (FWD_RD_W'(id_src[i*REG_AW +: REG_AW]) == w_s[0].rd)) begin
                w_src_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_flag_busy = 1'b0;
        for (int k = 0; k <= FWD_DEPTH; k++) begin
            w_flag_busy = w_flag_busy | (w_s[k].valid & w_s[k].setflags);
        end
    end

    // A squashed ID instruction never stalls; the flush bubble covers it.
    assign w_stall = ~flush & id_valid & w_s[0].memread &
                     entry_writes(w_s[0], c_ZERO_RD) & w_src_hit;

    assign fwd_sel        = w_fwd_sel;
    assign load_use_stall = w_stall;
    assign flag_fwd       = id_valid & id_branch & w_s[0].valid & w_s[0].setflags;
    assign flag_busy      = w_flag_busy;

endmodule
`default_nettype wire
